// File: rtl/pll_pkg.sv
// Shared definitions for the PLL loop sequencer: state encoding, datapath widths
// and default lock/unlock thresholds.
package pll_pkg;

    localparam int PE_W     = 8;
    localparam int LF_OUT_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_ACQ   = 2'd2,
        ST_TRACK = 2'd3
    } pll_state_t;

    localparam int DEF_LOCK_THRESH   = 4;
    localparam int DEF_UNLOCK_THRESH = 16;
    localparam int DEF_LOCK_CNT      = 64;
    localparam int DEF_UNLOCK_CNT    = 8;
    localparam int DEF_ACQ_TIMEOUT   = 4096;
    localparam int DEF_ACQ_SHIFT     = 1;
    localparam int DEF_TRK_SHIFT     = 1;
    localparam int DEF_LF_RST_CYC    = 4;

endpackage

// File: rtl/pll_err_scale.sv
// Combinational phase-error conditioning: 9-bit magnitude, saturating left
// shift for the wide acquire gain and flooring right shift for the track gain.
module pll_err_scale #(
    parameter int PE_W      = 8,
    parameter int ACQ_SHIFT = 1,
    parameter int TRK_SHIFT = 1
) (
    input  logic [PE_W-1:0] pe,
    output logic [PE_W:0]   abs_pe,
    output logic [PE_W-1:0] acq_val,
    output logic [PE_W-1:0] trk_val
);

    localparam int WIDE_W = PE_W + ACQ_SHIFT + 1;

    logic [PE_W:0]          pe_ext;
    logic [WIDE_W-1:0]      wide;
    logic [WIDE_W-PE_W:0]   wide_top;
    logic                   ovf;

    // One extra bit keeps |-128| = 128 representable.
    assign pe_ext = {pe[PE_W-1], pe};
    assign abs_pe = pe[PE_W-1] ? (~pe_ext + 1'b1) : pe_ext;

    assign wide     = {{(ACQ_SHIFT + 1){pe[PE_W-1]}}, pe} << ACQ_SHIFT;
    assign wide_top = wide[WIDE_W-1:PE_W-1];
    // Result fits only if every bit above the output sign bit matches it.
    assign ovf      = !((&wide_top) || (~|wide_top));
    assign acq_val  = ovf ? {wide[WIDE_W-1], {(PE_W-1){~wide[WIDE_W-1]}}}
                          : wide[PE_W-1:0];

    assign trk_val  = PE_W'($signed(pe) >>> TRK_SHIFT);

endmodule

// File: rtl/pll_loop_ctrl.sv
// Acquisition/tracking sequencer feeding the PLL loop filter.
// Optional build macro PLL_LOCK_LOSS_CNT_EN adds the saturating LOSS_CNT output.
module pll_loop_ctrl
    import pll_pkg::*;
#(
    parameter int LOCK_THRESH   = DEF_LOCK_THRESH,
    parameter int UNLOCK_THRESH = DEF_UNLOCK_THRESH,
    parameter int LOCK_CNT      = DEF_LOCK_CNT,
    parameter int UNLOCK_CNT    = DEF_UNLOCK_CNT,
    parameter int ACQ_TIMEOUT   = DEF_ACQ_TIMEOUT,
    parameter int ACQ_SHIFT     = DEF_ACQ_SHIFT,
    parameter int TRK_SHIFT     = DEF_TRK_SHIFT,
    parameter int LF_RST_CYC    = DEF_LF_RST_CYC
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            ENABLE,
    input  logic [PE_W-1:0] PE,
    input  logic            PE_VALID,
    output logic [PE_W-1:0] C_OUT,
    output logic            LF_RESET,
    output logic [1:0]      STATE,
    output logic            LOCKED,
`ifdef PLL_LOCK_LOSS_CNT_EN
    output logic [7:0]      LOSS_CNT,
`endif
    output logic            LOCK_LOST
);

    localparam int ABS_W = PE_W + 1;
    localparam int LK_W  = $clog2(LOCK_CNT + 1);
    localparam int UL_W  = $clog2(UNLOCK_CNT + 1);
    localparam int TO_W  = $clog2(ACQ_TIMEOUT + 1);
    localparam int FL_W  = $clog2(LF_RST_CYC + 1);

    localparam logic [ABS_W-1:0] LOCK_TH   = ABS_W'(LOCK_THRESH);
    localparam logic [ABS_W-1:0] UNLOCK_TH = ABS_W'(UNLOCK_THRESH);
    localparam logic [LK_W-1:0]  LK_LAST   = LK_W'(LOCK_CNT - 1);
    localparam logic [UL_W-1:0]  UL_LAST   = UL_W'(UNLOCK_CNT - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(ACQ_TIMEOUT - 1);
    localparam logic [FL_W-1:0]  FL_LAST   = FL_W'(LF_RST_CYC - 1);

    pll_state_t      state_reg, state_next;
    logic [LK_W-1:0] lock_cnt_reg, lock_cnt_next;
    logic [UL_W-1:0] unlock_cnt_reg, unlock_cnt_next;
    logic [TO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
    logic [FL_W-1:0] flush_cnt_reg, flush_cnt_next;
    logic [PE_W-1:0] c_out_reg, c_out_next;
    logic            lf_reset_reg, lf_reset_next;
    logic            locked_reg, locked_next;
    logic            lock_lost_reg, lock_lost_next;

    logic [ABS_W-1:0] abs_pe;
    logic [PE_W-1:0]  acq_val, trk_val;
    logic             in_lock, out_lock;

    pll_err_scale #(
        .PE_W      (PE_W),
        .ACQ_SHIFT (ACQ_SHIFT),
        .TRK_SHIFT (TRK_SHIFT)
    ) u_err_scale (
        .pe      (PE),
        .abs_pe  (abs_pe),
        .acq_val (acq_val),
        .trk_val (trk_val)
    );

    assign in_lock  = abs_pe <= LOCK_TH;
    assign out_lock = abs_pe >= UNLOCK_TH;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg      <= ST_IDLE;
            lock_cnt_reg   <= '0;
            unlock_cnt_reg <= '0;
            tmo_cnt_reg    <= '0;
            flush_cnt_reg  <= '0;
            c_out_reg      <= '0;
            lf_reset_reg   <= 1'b1;
            locked_reg     <= 1'b0;
            lock_lost_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            lock_cnt_reg   <= lock_cnt_next;
            unlock_cnt_reg <= unlock_cnt_next;
            tmo_cnt_reg    <= tmo_cnt_next;
            flush_cnt_reg  <= flush_cnt_next;
            c_out_reg      <= c_out_next;
            lf_reset_reg   <= lf_reset_next;
            locked_reg     <= locked_next;
            lock_lost_reg  <= lock_lost_next;
        end
    end

    // Counters idle at zero outside their own state, so every state entry starts clean.
    always_comb begin
        state_next      = state_reg;
        lock_cnt_next   = '0;
        unlock_cnt_next = '0;
        tmo_cnt_next    = '0;
        flush_cnt_next  = '0;
        if (!ENABLE) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: state_next = ST_FLUSH;
                ST_FLUSH: begin
                    if (flush_cnt_reg == FL_LAST) state_next = ST_ACQ;
                    else flush_cnt_next = flush_cnt_reg + 1'b1;
                end
                ST_ACQ: begin
                    lock_cnt_next = lock_cnt_reg;
                    tmo_cnt_next  = tmo_cnt_reg + 1'b1;
                    if (PE_VALID) lock_cnt_next = in_lock ? lock_cnt_reg + 1'b1 : '0;
                    // Lock takes priority over a coincident timeout.
                    if (PE_VALID && in_lock && lock_cnt_reg == LK_LAST) begin
                        state_next    = ST_TRACK;
                        lock_cnt_next = '0;
                        tmo_cnt_next  = '0;
                    end else if (tmo_cnt_reg == TO_LAST) begin
                        state_next    = ST_FLUSH;
                        lock_cnt_next = '0;
                        tmo_cnt_next  = '0;
                    end
                end
                ST_TRACK: begin
                    unlock_cnt_next = unlock_cnt_reg;
                    if (PE_VALID) unlock_cnt_next = out_lock ? unlock_cnt_reg + 1'b1 : '0;
                    if (PE_VALID && out_lock && unlock_cnt_reg == UL_LAST) begin
                        state_next      = ST_ACQ;
                        unlock_cnt_next = '0;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end

        // The deciding sample is scaled with the gain of the state it arrived in.
        c_out_next = '0;
        if (ENABLE && PE_VALID) begin
            if (state_reg == ST_ACQ)   c_out_next = acq_val;
            if (state_reg == ST_TRACK) c_out_next = trk_val;
        end
        lf_reset_next  = (state_next == ST_IDLE) || (state_next == ST_FLUSH);
        locked_next    = (state_next == ST_TRACK);
        lock_lost_next = (state_reg == ST_TRACK) && (state_next == ST_ACQ);
    end

`ifdef PLL_LOCK_LOSS_CNT_EN
    logic [7:0] loss_cnt_reg;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)                                    loss_cnt_reg <= '0;
        else if (lock_lost_next && loss_cnt_reg != 8'hFF) loss_cnt_reg <= loss_cnt_reg + 8'd1;
    end

    assign LOSS_CNT = loss_cnt_reg;
`endif

    assign C_OUT     = c_out_reg;
    assign LF_RESET  = lf_reset_reg;
    assign STATE     = state_reg;
    assign LOCKED    = locked_reg;
    assign LOCK_LOST = lock_lost_reg;

endmodule

// File: tb/tb_pll_loop_ctrl.sv
// Directed scoreboard bench for pll_loop_ctrl: each step queues the expected
// registered outputs and checks them one clock later.
module tb_pll_loop_ctrl;
    import pll_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       ENABLE;
    logic [7:0] PE;
    logic       PE_VALID;
    logic [7:0] C_OUT;
    logic       LF_RESET;
    logic [1:0] STATE;
    logic       LOCKED;
    logic       LOCK_LOST;
`ifdef PLL_LOCK_LOSS_CNT_EN
    logic [7:0] LOSS_CNT;
`endif

    pll_loop_ctrl dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .ENABLE    (ENABLE),
        .PE        (PE),
        .PE_VALID  (PE_VALID),
        .C_OUT     (C_OUT),
        .LF_RESET  (LF_RESET),
        .STATE     (STATE),
        .LOCKED    (LOCKED),
`ifdef PLL_LOCK_LOSS_CNT_EN
        .LOSS_CNT  (LOSS_CNT),
`endif
        .LOCK_LOST (LOCK_LOST)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] st;
        logic [7:0] c;
        logic       lf;
        logic       lk;
        logic       ll;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    int   step_no = 0;

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        tests++;
        assert (sb_q.size() != 0) else begin
            fails++;
            $error("FAIL scoreboard_empty step=%0d observed=0 expected=1", step_no);
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            cmp("STATE",     {6'd0, STATE},     {6'd0, e.st});
            cmp("C_OUT",     C_OUT,             e.c);
            cmp("LF_RESET",  {7'd0, LF_RESET},  {7'd0, e.lf});
            cmp("LOCKED",    {7'd0, LOCKED},    {7'd0, e.lk});
            cmp("LOCK_LOST", {7'd0, LOCK_LOST}, {7'd0, e.ll});
        end
    endtask

    task automatic step(input logic en, input logic v, input logic [7:0] pe,
                        input logic [1:0] st, input logic [7:0] c,
                        input logic lf, input logic lk, input logic ll);
        exp_t e;
        @(negedge CLK);
        ENABLE   = en;
        PE_VALID = v;
        PE       = pe;
        e.st = st; e.c = c; e.lf = lf; e.lk = lk; e.ll = ll;
        sb_q.push_back(e);
        @(posedge CLK);
        #1;
        step_no++;
        check_out();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog step=%0d observed=timeout expected=finish", step_no);
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET_N  = 1'b0;
        ENABLE   = 1'b0;
        PE       = 8'd0;
        PE_VALID = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        cmp("rst_STATE",     {6'd0, STATE},     8'd0);
        cmp("rst_C_OUT",     C_OUT,             8'd0);
        cmp("rst_LF_RESET",  {7'd0, LF_RESET},  8'd1);
        cmp("rst_LOCKED",    {7'd0, LOCKED},    8'd0);
        cmp("rst_LOCK_LOST", {7'd0, LOCK_LOST}, 8'd0);
`ifdef PLL_LOCK_LOSS_CNT_EN
        cmp("rst_LOSS_CNT", LOSS_CNT, 8'd0);
`endif
        @(negedge CLK);
        RESET_N = 1'b1;

        // Idle with enable low, then flush: four LF_RESET cycles before ACQ.
        step(1'b0, 1'b1, 8'd5, ST_IDLE, 8'd0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'd5, ST_FLUSH, 8'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'd5, ST_FLUSH, 8'd0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'd5, ST_ACQ, 8'd0, 1'b0, 1'b0, 1'b0);

        // Lock counter clear and acquire-gain saturation.
        for (int i = 0; i < 63; i++) step(1'b1, 1'b1, 8'd3, ST_ACQ, 8'd6, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'd100, ST_ACQ, 8'd127, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h80,  ST_ACQ, 8'h80,  1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'd2,   ST_ACQ, 8'd0,   1'b0, 1'b0, 1'b0);

        // Acquire lock: 64th in-lock sample moves to TRACK on the same edge.
        for (int i = 0; i < 63; i++) step(1'b1, 1'b1, 8'd2, ST_ACQ, 8'd4, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'd2, ST_TRACK, 8'd4, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'd2, ST_TRACK, 8'd1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, -8'sd3, ST_TRACK, -8'sd2, 1'b0, 1'b1, 1'b0);

        // Loss of lock: an in-range sample restarts the unlock count.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, -8'sd20, ST_TRACK, -8'sd10, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'd0, ST_TRACK, 8'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, -8'sd20, ST_TRACK, -8'sd10, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, -8'sd20, ST_ACQ, -8'sd10, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'd0, ST_ACQ, 8'd0, 1'b0, 1'b0, 1'b0);
`ifdef PLL_LOCK_LOSS_CNT_EN
        cmp("LOSS_CNT_after_loss", LOSS_CNT, 8'd1);
`endif

        // Timeout: 4096 cycles in ACQ (one already spent above) then re-flush.
        for (int i = 0; i < 4094; i++) step(1'b1, 1'b1, 8'd50, ST_ACQ, 8'd100, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'd50, ST_FLUSH, 8'd100, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'd50, ST_FLUSH, 8'd0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'd50, ST_ACQ, 8'd0, 1'b0, 1'b0, 1'b0);

        // Relock at the LOCK_THRESH boundary (|-4| = 4 is in lock).
        for (int i = 0; i < 63; i++) step(1'b1, 1'b1, -8'sd4, ST_ACQ, -8'sd8, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, -8'sd4, ST_TRACK, -8'sd8, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, -8'sd16, ST_TRACK, -8'sd8, 1'b0, 1'b1, 1'b0);

        // Disable mid-TRACK: straight to IDLE, no LOCK_LOST pulse.
        step(1'b0, 1'b0, 8'd0, ST_IDLE, 8'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'd7, ST_IDLE, 8'd0, 1'b1, 1'b0, 1'b0);
`ifdef PLL_LOCK_LOSS_CNT_EN
        cmp("LOSS_CNT_after_disable", LOSS_CNT, 8'd1);
`endif

        // Asynchronous reset between clock edges while flushing then acquiring.
        step(1'b1, 1'b0, 8'd0, ST_FLUSH, 8'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'd0, ST_FLUSH, 8'd0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'd1, ST_ACQ, 8'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'd1, ST_ACQ, 8'd2, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        #2;
        RESET_N = 1'b0;
        #1;
        cmp("arst_STATE",    {6'd0, STATE},    8'd0);
        cmp("arst_C_OUT",    C_OUT,            8'd0);
        cmp("arst_LF_RESET", {7'd0, LF_RESET}, 8'd1);
`ifdef PLL_LOCK_LOSS_CNT_EN
        cmp("arst_LOSS_CNT", LOSS_CNT, 8'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
